// File: rtl/age_sweep_tx_if.sv
// age_sweep_tx_if: valid/ready stream that carries one age value and its
// reference classification tag from the sweep transmitter to a receiver.
interface age_sweep_tx_if #(
  parameter int AGE_W = 8
);
  logic [AGE_W-1:0] age;
  logic [2:0]       tag;
  logic             valid;
  logic             ready;

  modport master (
    output age,
    output tag,
    output valid,
    input  ready
  );

  modport slave (
    input  age,
    input  tag,
    input  valid,
    output ready
  );
endinterface

// File: rtl/age_sweep_tx.sv
// age_sweep_tx: streams ages AGE_MIN, AGE_MIN+STEP, ... up to AGE_MAX over a
// valid/ready handshake. Each age travels with a tag holding the expected
// eligibility result so the receiving classifier can be checked directly.
// Build option AGE_SWEEP_TX_WRAP_EN: the sweep wraps back to AGE_MIN forever
// (done pulses at each wrap) instead of ending after a single pass.
module age_sweep_tx #(
  parameter int AGE_W   = 8,
  parameter int AGE_MIN = 0,
  parameter int AGE_MAX = 40,
  parameter int STEP    = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  age_sweep_tx_if.master tx,
  output logic           busy,
  output logic           done,
  output logic [15:0]    sent_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // The sum is formed one bit wider so that age+STEP past the top of the
  // AGE_W range still compares correctly against AGE_MAX.
  localparam logic [AGE_W-1:0] AGE_FIRST = AGE_W'(AGE_MIN);
  localparam logic [AGE_W:0]   AGE_LAST  = (AGE_W+1)'(AGE_MAX);
  localparam logic [AGE_W:0]   AGE_INC   = (AGE_W+1)'(STEP);

  logic [1:0]       state;
  logic [AGE_W-1:0] age_q;
  logic [2:0]       tag_q;
  logic             valid_q;
  logic [AGE_W:0]   age_sum;
  logic             xfer;
  logic             past_end;

  // Reference classification: bit0 vote (>18), bit1 candidate (>30), bit2 age==10.
  function automatic logic [2:0] classify(input logic [AGE_W-1:0] a);
    logic [31:0] v;
    v = 32'(a);
    return {v == 32'd10, v > 32'd30, v > 32'd18};
  endfunction

  // Handshake decode and next-age arithmetic.
  always_comb begin
    xfer     = valid_q && tx.ready;
    age_sum  = {1'b0, age_q} + AGE_INC;
    past_end = age_sum > AGE_LAST;
  end

  // Sweep sequencer: every output is a register, so ready only steers state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      age_q    <= '0;
      tag_q    <= '0;
      valid_q  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sent_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_SEND;
            age_q    <= AGE_FIRST;
            tag_q    <= classify(AGE_FIRST);
            valid_q  <= 1'b1;
            busy     <= 1'b1;
            sent_cnt <= '0;
          end
        end

        S_SEND: begin
          // A transfer landing on the same edge as abort still counts.
          if (xfer && sent_cnt != 16'hFFFF) begin
            sent_cnt <= sent_cnt + 16'd1;
          end
          if (abort) begin
            state   <= S_IDLE;
            valid_q <= 1'b0;
            busy    <= 1'b0;
          end else if (xfer) begin
            if (past_end) begin
`ifdef AGE_SWEEP_TX_WRAP_EN
              age_q <= AGE_FIRST;
              tag_q <= classify(AGE_FIRST);
              done  <= 1'b1;
`else
              state   <= S_DONE;
              valid_q <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
`endif
            end else begin
              age_q <= age_sum[AGE_W-1:0];
              tag_q <= classify(age_sum[AGE_W-1:0]);
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state   <= S_IDLE;
          valid_q <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  assign tx.age   = age_q;
  assign tx.tag   = tag_q;
  assign tx.valid = valid_q;

endmodule

// File: tb/tb_age_sweep_tx.sv
// tb_age_sweep_tx: directed bench for age_sweep_tx. Instance dut0 uses the
// default parameters, dut7 uses STEP=7. Honors AGE_SWEEP_TX_WRAP_EN.
module tb_age_sweep_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        start7;
  logic        abort7;
  logic        busy0;
  logic        done0;
  logic [15:0] cnt0;
  logic        busy7;
  logic        done7;
  logic [15:0] cnt7;

  int checks = 0;
  int errors = 0;

  age_sweep_tx_if #(.AGE_W(8)) bus0 ();
  age_sweep_tx_if #(.AGE_W(8)) bus7 ();

  age_sweep_tx dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .tx       (bus0),
    .busy     (busy0),
    .done     (done0),
    .sent_cnt (cnt0)
  );

  age_sweep_tx #(.AGE_W(8), .AGE_MIN(0), .AGE_MAX(40), .STEP(7)) dut7 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start7),
    .abort    (abort7),
    .tx       (bus7),
    .busy     (busy7),
    .done     (done7),
    .sent_cnt (cnt7)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] ref_tag(input int a);
    return {a == 10, a > 30, a > 18};
  endfunction

  // Directed sequence.
  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    start7    = 1'b0;
    abort7    = 1'b0;
    bus0.ready = 1'b0;
    bus7.ready = 1'b1;

    #2;
    check_output("rst_age",   32'(bus0.age), 0);
    check_output("rst_tag",   32'(bus0.tag), 0);
    check_output("rst_valid", 32'(bus0.valid), 0);
    check_output("rst_busy",  32'(busy0), 0);
    check_output("rst_done",  32'(done0), 0);
    check_output("rst_cnt",   32'(cnt0), 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check_output("idle_valid", 32'(bus0.valid), 0);

    // Full sweep with ready held high.
    bus0.ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
`ifdef AGE_SWEEP_TX_WRAP_EN
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i <= 40; i++) begin
        check_output("sweep_age",   32'(bus0.age), 32'(i));
        check_output("sweep_valid", 32'(bus0.valid), 1);
        check_output("sweep_busy",  32'(busy0), 1);
        check_output("sweep_done",  32'(done0), (pass == 1 && i == 0) ? 1 : 0);
        check_output("sweep_tag",   32'(bus0.tag), 32'(ref_tag(i)));
        step();
      end
    end
    check_output("wrap_age",   32'(bus0.age), 0);
    check_output("wrap_valid", 32'(bus0.valid), 1);
    check_output("wrap_done",  32'(done0), 1);
    check_output("wrap_busy",  32'(busy0), 1);
    check_output("wrap_cnt",   32'(cnt0), 82);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_output("wrap_abort_valid", 32'(bus0.valid), 0);
    check_output("wrap_abort_busy",  32'(busy0), 0);
    check_output("wrap_abort_done",  32'(done0), 0);
    check_output("wrap_abort_cnt",   32'(cnt0), 83);
    step();
`else
    for (int i = 0; i <= 40; i++) begin
      check_output("sweep_age",   32'(bus0.age), 32'(i));
      check_output("sweep_valid", 32'(bus0.valid), 1);
      check_output("sweep_busy",  32'(busy0), 1);
      check_output("sweep_done",  32'(done0), 0);
      check_output("sweep_tag",   32'(bus0.tag), 32'(ref_tag(i)));
      if (i == 10) check_output("tag_10", 32'(bus0.tag), 32'(3'b100));
      if (i == 19) check_output("tag_19", 32'(bus0.tag), 32'(3'b001));
      if (i == 30) check_output("tag_30", 32'(bus0.tag), 32'(3'b001));
      if (i == 31) check_output("tag_31", 32'(bus0.tag), 32'(3'b011));
      step();
    end
    check_output("end_done",  32'(done0), 1);
    check_output("end_valid", 32'(bus0.valid), 0);
    check_output("end_busy",  32'(busy0), 0);
    check_output("end_cnt",   32'(cnt0), 41);
    step();
    check_output("post_done",  32'(done0), 0);
    check_output("post_valid", 32'(bus0.valid), 0);
    check_output("post_cnt",   32'(cnt0), 41);
    step();
    check_output("idle_cnt", 32'(cnt0), 41);
`endif

    // Backpressure at age 17, then abort at age 20 with ready low.
    start = 1'b1;
    step();
    start = 1'b0;
    check_output("bp_first_age", 32'(bus0.age), 0);
    check_output("bp_first_cnt", 32'(cnt0), 0);
    repeat (17) step();
    check_output("bp_age17", 32'(bus0.age), 17);
    bus0.ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_output("bp_hold_age",   32'(bus0.age), 17);
      check_output("bp_hold_tag",   32'(bus0.tag), 32'(3'b000));
      check_output("bp_hold_valid", 32'(bus0.valid), 1);
    end
    bus0.ready = 1'b1;
    step();
    check_output("bp_age18", 32'(bus0.age), 18);
    check_output("bp_tag18", 32'(bus0.tag), 32'(3'b000));
    step();
    check_output("bp_age19", 32'(bus0.age), 19);
    check_output("bp_tag19", 32'(bus0.tag), 32'(3'b001));
    step();
    check_output("bp_age20", 32'(bus0.age), 20);
    bus0.ready = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_output("abort_valid", 32'(bus0.valid), 0);
    check_output("abort_busy",  32'(busy0), 0);
    check_output("abort_done",  32'(done0), 0);
    check_output("abort_cnt",   32'(cnt0), 20);
    step();
    check_output("abort_done2", 32'(done0), 0);
    check_output("abort_cnt2",  32'(cnt0), 20);

    // Abort while idle changes nothing.
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_output("idle_abort_valid", 32'(bus0.valid), 0);
    check_output("idle_abort_cnt",   32'(cnt0), 20);

    // STEP=7 instance.
    start7 = 1'b1;
    step();
    start7 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check_output("s7_age",   32'(bus7.age), 32'(k * 7));
      check_output("s7_valid", 32'(bus7.valid), 1);
      if (k == 5) check_output("s7_tag35", 32'(bus7.tag), 32'(3'b011));
      step();
    end
    check_output("s7_done", 32'(done7), 1);
    check_output("s7_cnt",  32'(cnt7), 6);
`ifdef AGE_SWEEP_TX_WRAP_EN
    check_output("s7_wrap_age",   32'(bus7.age), 0);
    check_output("s7_wrap_valid", 32'(bus7.valid), 1);
    abort7 = 1'b1;
    step();
    abort7 = 1'b0;
    check_output("s7_abort_valid", 32'(bus7.valid), 0);
`else
    check_output("s7_end_valid", 32'(bus7.valid), 0);
    step();
    check_output("s7_post_done", 32'(done7), 0);
`endif

    // Asynchronous reset in the middle of a sweep.
    bus0.ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    check_output("mid_age", 32'(bus0.age), 3);
    check_output("mid_cnt", 32'(cnt0), 3);
    #3;
    rst_n = 1'b0;
    #1;
    check_output("arst_age",   32'(bus0.age), 0);
    check_output("arst_tag",   32'(bus0.tag), 0);
    check_output("arst_valid", 32'(bus0.valid), 0);
    check_output("arst_busy",  32'(busy0), 0);
    check_output("arst_done",  32'(done0), 0);
    check_output("arst_cnt",   32'(cnt0), 0);
    step();
    rst_n = 1'b1;
    step();
    check_output("rel_valid", 32'(bus0.valid), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check_output("restart_age",   32'(bus0.age), 0);
    check_output("restart_valid", 32'(bus0.valid), 1);
    check_output("restart_cnt",   32'(cnt0), 0);
    step();
    check_output("restart_age1", 32'(bus0.age), 1);
    check_output("restart_cnt1", 32'(cnt0), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_output("final_valid", 32'(bus0.valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/age_sweep_tx.md
# age_sweep_tx

Transmitter that streams a sweep of age values over a valid/ready handshake to downstream age-eligibility classifiers, which are the receiving end. Each transmitted age carries a reference tag, the expected classification result, so the receiver's decision can be checked on the spot. The block sits in the verification/demo fabric as the stimulus source for the conditional-logic blocks.

## Interface
Parameters:
- AGE_W, 8: width of the age value.
- AGE_MIN, 0: first age of a sweep.
- AGE_MAX, 40: last legal age of a sweep. Must satisfy AGE_MIN <= AGE_MAX < 2**AGE_W.
- STEP, 1: increment between transmitted ages. Must be >= 1.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a sweep; ignored unless in IDLE.
- abort  in  1  ends a running sweep early.
- age  out  AGE_W  current age; valid only when valid=1.
- tag  out  3  reference classification of age:
  - [0] = age>18 (vote)
  - [1] = age>30 (candidate)
  - [2] = age==10
- valid  out  1  age/tag are presented.
- ready  in  1  receiver accepts this cycle.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at sweep completion.
- sent_cnt  out  16  number of accepted transfers in the current sweep.

## Operation
- Reset value of every output is 0: age=0, tag=0, valid=0, busy=0, done=0, sent_cnt=0. State after reset is IDLE.
- States are IDLE, SEND and DONE.
- IDLE:
  - valid=0, busy=0.
  - On start: load age=AGE_MIN, clear sent_cnt, go to SEND.
- SEND:
  - valid=1, busy=1.
  - A transfer occurs when valid && ready.
  - On each transfer, sent_cnt increments, saturating at 16'hFFFF.
  - The next age is computed in AGE_W+1 bits. If age+STEP > AGE_MAX, go to DONE. Otherwise age <= age+STEP.
- DONE: done=1, valid=0, busy=0 for exactly one cycle, then go to IDLE.
- Handshake rules:
  - Once valid rises, age and tag stay stable until a transfer occurs.
  - valid never deasserts without a transfer, except on abort or reset.
- tag is registered together with age and is always consistent with the age currently presented.
- Abort:
  - In SEND, abort goes to IDLE on the next edge. No done pulse; sent_cnt holds.
  - If a transfer coincides with abort, that transfer counts.
  - abort in IDLE or DONE has no effect.
- Simultaneous start and abort in IDLE: start wins.
- sent_cnt holds its value in IDLE until the next start.
- Reset asserted mid-sweep forces IDLE and all outputs to 0 immediately (asynchronous). Deassertion takes effect on the next clk edge.

## Timing
- start sampled at edge N → valid=1 with age=AGE_MIN after edge N.
- With ready held at 1, one transfer per cycle and no bubbles.
- Last transfer at edge M → done high for the cycle after edge M, back in IDLE after edge M+1.
- A new start is accepted from the IDLE cycle following done.
- ready has no combinational path to any output. All outputs come from registers.

## Configuration
- Macro: AGE_SWEEP_TX_WRAP_EN.
- Defined:
  - When age+STEP > AGE_MAX on a transfer, age reloads AGE_MIN and the block stays in SEND; valid never drops.
  - done pulses for one cycle coincident with the reload, while busy stays 1.
  - The DONE state is unused. Only abort or reset ends a sweep.
- Undefined: single sweep per start, as described in Operation.

## Test plan
- Defaults, ready=1, one start pulse:
  - ages 0..40 on 41 consecutive cycles.
  - done pulses once, the cycle after age 40 is accepted.
  - sent_cnt=41; busy drops together with valid.
- Backpressure:
  - ready=0 for 3 cycles while age=17 → age=17, tag=3'b000, valid=1 held.
  - Then ready=1 → 18 (tag 000), then 19 (tag 001).
- Tag check:
  - age 10 → 3'b100.
  - age 30 → 3'b001.
  - age 31 → 3'b011.
  - age 19 → 3'b001.
- STEP=7, AGE_MAX=40, ready=1:
  - ages 0,7,14,21,28,35, then done.
  - sent_cnt=6; tag of 35 = 3'b011.
- Abort and reset:
  - abort while age=20 and ready=0 → valid=0 next cycle, no done, sent_cnt=20.
  - rst_n low mid-sweep → all outputs 0 immediately; start after release restarts at 0.
- With AGE_SWEEP_TX_WRAP_EN, ready=1:
  - after 40 the next age is 0 with no valid gap.
  - done pulses coincident with age 0.
  - sent_cnt=82 after two full passes.
